busdec_n: RTL and testbench

//   N-way sequential bus decoder. Sits between one bus master (core LSU/fetch)
//   and NDEV memory-mapped devices. Each device has its own BASE/MASK window.
//   Per transaction it: decodes, pulses the hit device's enable, and waits for
//   a device acknowledge. It then returns registered read data, ack and error
//   to the master. Unmapped addresses and silent devices raise a bus error.

---
 rtl/busdec_n.sv | 199 +++++++++++++++++++
 tb/tb_busdec_n.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/busdec_n.sv
// Purpose : N-way sequential bus decoder between one master and NDEV memory-mapped devices.
// Latency : 2 cycles from req to ack for a same-cycle device or an unmapped address; timeout after TIMEOUT wait cycles.
// Backpres: one transaction in flight; req is ignored while busy and re-sampled in the ack cycle (no bubble).
//
// Ports:
//   i_clk, i_rst      clock (rising edge), asynchronous active-high reset
//   i_req, i_addr     master request and address, sampled only while idle
//   o_ack, o_err      one-cycle completion pulse; err marks unmapped address or timeout
//   o_rdata           registered read data, valid while ack=1 and err=0
//   o_busy            high from accepted req up to (not including) the ack cycle
//   o_dev_en          one-hot, one-cycle enable pulse to the selected device
//   o_dev_addr        latched low MASK address bits, stable for the whole transaction
//   i_dev_ack         per-device done; only the selected bit is honoured
//   i_dev_rdata       per-device read data, device i at [32*i +: 32]
module busdec_n #(
  parameter int                 NDEV    = 4,
  parameter int                 MASK    = 4,
  parameter logic [NDEV*32-1:0] BASES   = '0,
  parameter int                 TIMEOUT = 15
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_req,
  input  logic [31:0]          i_addr,
  output logic                 o_ack,
  output logic                 o_err,
  output logic [31:0]          o_rdata,
  output logic                 o_busy,
  output logic [NDEV-1:0]      o_dev_en,
  output logic [MASK-1:0]      o_dev_addr,
  input  logic [NDEV-1:0]      i_dev_ack,
  input  logic [NDEV*32-1:0]   i_dev_rdata
);

  localparam int         SELW     = (NDEV > 1) ? $clog2(NDEV) : 1;
  // Wait counter compares against this value; it never wraps because the
  // timeout branch fires first.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  state_t          r_state;
  logic            r_ack;
  logic            r_err;
  logic [31:0]     r_rdata;
  logic            r_busy;
  logic [NDEV-1:0] r_dev_en;
  logic [MASK-1:0] r_dev_addr;
  logic [SELW-1:0] r_sel;
  logic [7:0]      r_cnt;

  state_t          w_state_nxt;
  logic            w_ack_nxt;
  logic            w_err_nxt;
  logic [31:0]     w_rdata_nxt;
  logic            w_busy_nxt;
  logic [NDEV-1:0] w_dev_en_nxt;
  logic [MASK-1:0] w_dev_addr_nxt;
  logic [SELW-1:0] w_sel_nxt;
  logic [7:0]      w_cnt_nxt;

  logic [NDEV-1:0] w_hit;
  logic            w_any_hit;
  logic [SELW-1:0] w_hit_sel;
  logic [NDEV-1:0] w_hit_oh;
  logic            w_sel_ack;
  logic [31:0]     w_sel_rdata;

  // Window match: only the bits above the window offset take part.
  always_comb begin
    w_hit = '0;
    for (int i = 0; i < NDEV; i++) begin
      w_hit[i] = (i_addr[31:MASK] == BASES[32*i+MASK +: 32-MASK]);
    end
  end

  // Priority encode: scanning downwards lets the lowest matching index
  // overwrite any higher one, so overlapping windows resolve to the lowest.
  always_comb begin
    w_any_hit = 1'b0;
    w_hit_sel = '0;
    for (int i = NDEV - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_any_hit = 1'b1;
        w_hit_sel = SELW'(i);
      end
    end
  end

  // One-hot enable built from the encoded winner, never from w_hit, so a
  // multi-window hit still yields a single enable.
  always_comb begin
    w_hit_oh = '0;
    for (int i = 0; i < NDEV; i++) begin
      w_hit_oh[i] = w_any_hit && (w_hit_sel == SELW'(i));
    end
  end

  // Only the latched device is listened to; everything else on the ack bus
  // is ignored.
  assign w_sel_ack   = i_dev_ack[r_sel];
  assign w_sel_rdata = i_dev_rdata[{r_sel, 5'b00000} +: 32];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_rdata    <= '0;
      r_busy     <= 1'b0;
      r_dev_en   <= '0;
      r_dev_addr <= '0;
      r_sel      <= '0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ack      <= w_ack_nxt;
      r_err      <= w_err_nxt;
      r_rdata    <= w_rdata_nxt;
      r_busy     <= w_busy_nxt;
      r_dev_en   <= w_dev_en_nxt;
      r_dev_addr <= w_dev_addr_nxt;
      r_sel      <= w_sel_nxt;
      r_cnt      <= w_cnt_nxt;
    end
  end

  // Next-state and next-output logic. ack/err/dev_en default to zero so
  // they can only ever be single-cycle pulses.
  always_comb begin
    w_state_nxt    = r_state;
    w_ack_nxt      = 1'b0;
    w_err_nxt      = 1'b0;
    w_rdata_nxt    = r_rdata;
    w_busy_nxt     = r_busy;
    w_dev_en_nxt   = '0;
    w_dev_addr_nxt = r_dev_addr;
    w_sel_nxt      = r_sel;
    w_cnt_nxt      = r_cnt;

    case (r_state)
      S_IDLE: begin
        if (i_req) begin
          w_busy_nxt = 1'b1;
          if (w_any_hit) begin
            w_sel_nxt      = w_hit_sel;
            w_dev_addr_nxt = i_addr[MASK-1:0];
            w_dev_en_nxt   = w_hit_oh;
            w_cnt_nxt      = '0;
            w_state_nxt    = S_WAIT;
          end else begin
            w_state_nxt = S_ERR;
          end
        end
      end

      S_WAIT: begin
        // Device ack is checked before the timeout so a same-edge ack wins.
        if (w_sel_ack) begin
          w_rdata_nxt = w_sel_rdata;
          w_ack_nxt   = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_ack_nxt   = 1'b1;
          w_err_nxt   = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end

      S_ERR: begin
        w_ack_nxt   = 1'b1;
        w_err_nxt   = 1'b1;
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign o_ack      = r_ack;
  assign o_err      = r_err;
  assign o_rdata    = r_rdata;
  assign o_busy     = r_busy;
  assign o_dev_en   = r_dev_en;
  assign o_dev_addr = r_dev_addr;

endmodule

// File: tb/tb_busdec_n.sv
// Purpose : self-checking bench for busdec_n (directed scenarios plus random traffic).
// Latency : n/a (bench).
// Backpres: n/a (bench).
module tb_busdec_n;

  localparam int NDEV    = 4;
  localparam int MASK    = 4;
  localparam int TIMEOUT = 4;
  localparam logic [31:0] B0 = 32'h1000_0000;
  localparam logic [31:0] B1 = 32'h2000_0010;
  localparam logic [31:0] B2 = 32'h1000_0000; // overlaps device 0
  localparam logic [31:0] B3 = 32'h3000_0000;

  logic               clk;
  logic               rst;
  logic               req;
  logic [31:0]        addr;
  logic               o_ack;
  logic               o_err;
  logic [31:0]        o_rdata;
  logic               o_busy;
  logic [NDEV-1:0]    o_dev_en;
  logic [MASK-1:0]    o_dev_addr;
  logic [NDEV-1:0]    dev_ack;
  logic [NDEV*32-1:0] dev_rdata;

  busdec_n #(
    .NDEV   (NDEV),
    .MASK   (MASK),
    .BASES  ({B3, B2, B1, B0}),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_req      (req),
    .i_addr     (addr),
    .o_ack      (o_ack),
    .o_err      (o_err),
    .o_rdata    (o_rdata),
    .o_busy     (o_busy),
    .o_dev_en   (o_dev_en),
    .o_dev_addr (o_dev_addr),
    .i_dev_ack  (dev_ack),
    .i_dev_rdata(dev_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] base_tab [NDEV];

  // Transaction-level reference: is a transfer in flight, what did it hit,
  // and how many edges have passed since it was accepted.
  bit          m_inflight;
  bit          m_hit;
  int          m_sel;
  int          m_age;
  logic        e_ack;
  logic        e_err;
  logic [31:0] e_rdata;
  logic        e_busy;
  logic [3:0]  e_dev_en;
  logic [3:0]  e_dev_addr;

  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < NDEV; i++) begin
      if ((a >> MASK) == (base_tab[i] >> MASK)) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_inflight = 0;
    m_hit      = 0;
    m_sel      = 0;
    m_age      = 0;
    e_ack      = 1'b0;
    e_err      = 1'b0;
    e_rdata    = '0;
    e_busy     = 1'b0;
    e_dev_en   = '0;
    e_dev_addr = '0;
  endtask

  // Outputs expected during the cycle following this rising edge.
  task automatic model_edge();
    int idx;
    e_ack    = 1'b0;
    e_err    = 1'b0;
    e_dev_en = '0;
    if (!m_inflight) begin
      if (req) begin
        idx        = decode(addr);
        m_inflight = 1;
        m_age      = 0;
        e_busy     = 1'b1;
        if (idx >= 0) begin
          m_hit      = 1;
          m_sel      = idx;
          e_dev_en   = 4'(1 << idx);
          e_dev_addr = addr[3:0];
        end else begin
          m_hit = 0;
        end
      end
    end else begin
      m_age = m_age + 1;
      if (!m_hit) begin
        e_ack = 1'b1; e_err = 1'b1; e_busy = 1'b0; m_inflight = 0;
      end else if (dev_ack[m_sel]) begin
        e_ack = 1'b1; e_rdata = dev_rdata[m_sel*32 +: 32]; e_busy = 1'b0; m_inflight = 0;
      end else if (m_age == TIMEOUT) begin
        e_ack = 1'b1; e_err = 1'b1; e_busy = 1'b0; m_inflight = 0;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("ack",      32'(o_ack),      32'(e_ack));
    chk("err",      32'(o_err),      32'(e_err));
    chk("rdata",    o_rdata,         e_rdata);
    chk("busy",     32'(o_busy),     32'(e_busy));
    chk("dev_en",   32'(o_dev_en),   32'(e_dev_en));
    chk("dev_addr", 32'(o_dev_addr), 32'(e_dev_addr));
  endtask

  // One clock: DUT and model both consume the inputs at the rising edge,
  // outputs are compared at the falling edge, then the caller drives new inputs.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    req     = 1'b0;
    dev_ack = '0;
    repeat (n) cycle();
  endtask

  function automatic logic [31:0] pick_addr();
    int r;
    r = $urandom_range(0, 4);
    if (r < NDEV) return {base_tab[r][31:4], 4'($urandom)};
    return $urandom;
  endfunction

  initial begin
    base_tab[0] = B0; base_tab[1] = B1; base_tab[2] = B2; base_tab[3] = B3;
    rst = 1'b1; req = 1'b0; addr = '0; dev_ack = '0; dev_rdata = '0;
    model_reset();

    // Reset values
    #12;
    chk("rst_ack",   32'(o_ack), 32'd0);
    chk("rst_err",   32'(o_err), 32'd0);
    chk("rst_rdata", o_rdata, 32'd0);
    chk("rst_busy",  32'(o_busy), 32'd0);
    chk("rst_den",   32'(o_dev_en), 32'd0);
    chk("rst_daddr", 32'(o_dev_addr), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    // Hit with immediate device ack
    req = 1'b1; addr = 32'h2000_0014;
    cycle();
    chk("t2_den",   32'(o_dev_en), 32'h2);
    chk("t2_daddr", 32'(o_dev_addr), 32'h4);
    chk("t2_busy",  32'(o_busy), 32'd1);
    req = 1'b0; dev_ack = 4'b0010; dev_rdata = '0; dev_rdata[63:32] = 32'hCAFE_F00D;
    cycle();
    chk("t2_ack",   32'(o_ack), 32'd1);
    chk("t2_err",   32'(o_err), 32'd0);
    chk("t2_rdata", o_rdata, 32'hCAFE_F00D);
    chk("t2_busy2", 32'(o_busy), 32'd0);
    idle(2);

    // Asynchronous reset in the middle of a wait on device 1
    req = 1'b1; addr = 32'h2000_0018; dev_rdata = '0;
    cycle();
    req = 1'b0;
    cycle();
    chk("t1_busy_pre", 32'(o_busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("t1_busy", 32'(o_busy), 32'd0);
    chk("t1_den",  32'(o_dev_en), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    idle(4);
    req = 1'b1; addr = 32'h1000_0003;
    cycle();
    chk("t1_new_busy", 32'(o_busy), 32'd1);
    chk("t1_new_den",  32'(o_dev_en), 32'h1);
    req = 1'b0; dev_ack = 4'b0001; dev_rdata[31:0] = 32'h1234_5678;
    cycle();
    chk("t1_new_ack", 32'(o_ack), 32'd1);
    idle(2);

    // Unmapped address
    req = 1'b1; addr = 32'hDEAD_0000;
    cycle();
    chk("t3_busy1", 32'(o_busy), 32'd1);
    chk("t3_den",   32'(o_dev_en), 32'd0);
    chk("t3_ack1",  32'(o_ack), 32'd0);
    req = 1'b0;
    cycle();
    chk("t3_ack",   32'(o_ack), 32'd1);
    chk("t3_err",   32'(o_err), 32'd1);
    chk("t3_busy2", 32'(o_busy), 32'd0);
    idle(2);

    // Timeout with a silent device 3
    req = 1'b1; addr = 32'h3000_0008;
    for (int c = 1; c <= 5; c++) begin
      cycle();
      req = 1'b0;
      if (c < 5) chk("t4_noack", 32'(o_ack), 32'd0);
    end
    chk("t4_ack", 32'(o_ack), 32'd1);
    chk("t4_err", 32'(o_err), 32'd1);
    idle(2);

    // Same device acking on the very edge the timeout would fire
    req = 1'b1; addr = 32'h3000_0008;
    for (int c = 1; c <= 4; c++) begin
      cycle();
      req = 1'b0;
    end
    dev_ack = 4'b1000; dev_rdata[127:96] = 32'h0BAD_BEEF;
    cycle();
    chk("t4b_ack",   32'(o_ack), 32'd1);
    chk("t4b_err",   32'(o_err), 32'd0);
    chk("t4b_rdata", o_rdata, 32'h0BAD_BEEF);
    idle(2);

    // Overlapping windows: device 0 beats device 2, device 2 ack ignored
    req = 1'b1; addr = 32'h1000_0004;
    cycle();
    chk("t5_den", 32'(o_dev_en), 32'h1);
    req = 1'b0; dev_ack = 4'b0100;
    cycle();
    chk("t5_noack1", 32'(o_ack), 32'd0);
    cycle();
    chk("t5_noack2", 32'(o_ack), 32'd0);
    dev_ack = 4'b0001; dev_rdata[31:0] = 32'h5555_AAAA;
    cycle();
    chk("t5_ack",   32'(o_ack), 32'd1);
    chk("t5_rdata", o_rdata, 32'h5555_AAAA);
    idle(2);

    // Back-to-back: dev0, dev3, dev0 with req held high
    req = 1'b1; addr = 32'h1000_0001;
    cycle();
    chk("t6_den1", 32'(o_dev_en), 32'h1);
    dev_ack = 4'b0001; addr = 32'h3000_0002;
    cycle();
    chk("t6_ack2", 32'(o_ack), 32'd1);
    dev_ack = '0;
    cycle();
    chk("t6_noack3", 32'(o_ack), 32'd0);
    chk("t6_den3",   32'(o_dev_en), 32'h8);
    chk("t6_busy3",  32'(o_busy), 32'd1);
    dev_ack = 4'b1000; addr = 32'h1000_0009;
    cycle();
    chk("t6_ack4", 32'(o_ack), 32'd1);
    dev_ack = '0;
    cycle();
    chk("t6_noack5", 32'(o_ack), 32'd0);
    chk("t6_den5",   32'(o_dev_en), 32'h1);
    dev_ack = 4'b0001; req = 1'b0;
    cycle();
    chk("t6_ack6", 32'(o_ack), 32'd1);
    idle(2);

    // Random traffic against the reference model
    for (int n = 0; n < 3000; n++) begin
      req       = ($urandom_range(0, 2) != 0);
      addr      = pick_addr();
      dev_ack   = 4'($urandom & $urandom);
      dev_rdata = {$urandom, $urandom, $urandom, $urandom};
      cycle();
    end
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
